// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared types, widths and grant helper for the CDB arbiter
// Purpose: common definitions imported by the CDB arbiter interface, FIFO and top.
//   ROBSIZE     : default ROB entry id width
//   cdb_src_e   : broadcast source encoding (ALU = 0, LSB = 1)
//   rr_pick     : round-robin choice between the two producers
package cdb_arbiter_pkg;

  localparam int ROBSIZE = 4;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  // With both sources requesting, the one that did not win last time gets the bus.
  function automatic cdb_src_e rr_pick(input logic alu_req, input logic lsb_req,
                                       input cdb_src_e last);
    if (alu_req && lsb_req) return (last == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
    else if (alu_req)       return CDB_SRC_ALU;
    else                    return CDB_SRC_LSB;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer, control and broadcast signals of the CDB arbiter
// Purpose: bundles everything except clk/rst.
//   rdy, clear                      : global ready and mispredict flush
//   alu_valid/rob_id/value, alu_full: ALU producer side
//   lsb_valid/rob_id/value, lsb_full: load producer side
//   cdb_valid/rob_id/value/src      : registered broadcast
//   overflow_err                    : sticky push-while-full flag
//   modport slave = arbiter, modport master = environment
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(parameter int ROB_ID_W = ROBSIZE);

  logic                rdy;
  logic                clear;
  logic                alu_valid;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [31:0]         alu_value;
  logic                alu_full;
  logic                lsb_valid;
  logic [ROB_ID_W-1:0] lsb_rob_id;
  logic [31:0]         lsb_value;
  logic                lsb_full;
  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [31:0]         cdb_value;
  logic                cdb_src;
  logic                overflow_err;

  modport slave (
    input  rdy, clear,
    input  alu_valid, alu_rob_id, alu_value, lsb_valid, lsb_rob_id, lsb_value,
    output alu_full, lsb_full,
    output cdb_valid, cdb_rob_id, cdb_value, cdb_src, overflow_err
  );

  modport master (
    output rdy, clear,
    output alu_valid, alu_rob_id, alu_value, lsb_valid, lsb_rob_id, lsb_value,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_rob_id, cdb_value, cdb_src, overflow_err
  );

endinterface

// File: rtl/cdb_arbiter_fifo.sv
// rtl/cdb_arbiter_fifo.sv - per-source result FIFO feeding the CDB arbiter
// Purpose: DEPTH-entry FIFO (DEPTH a power of 2, >= 2) with rdy freeze and flush.
//   clk, rst      : clock, asynchronous active-high reset
//   i_rdy         : low freezes pointers, count and contents
//   i_clear       : empties the FIFO, discarding any push in the same cycle
//   i_push/i_data : write request; ignored while full
//   i_pop         : remove head; ignored while empty
//   o_head        : head entry
//   o_empty/o_full: occupancy flags from registered count
module cdb_arbiter_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rdy,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_rdy && !i_clear && i_push && !o_full;
  assign w_do_pop  = i_rdy && !i_clear && i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_rdy) begin
      if (i_clear) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_push) r_wptr <= r_wptr + PW'(1);
        if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing the common data bus between ALU and LSB
// Purpose: buffers ALU and load results per source, broadcasts one per cycle on a
// registered CDB, round-robin under contention, flushed by a mispredict clear.
//   clk, rst : clock, asynchronous active-high reset
//   io_bus   : cdb_arbiter_if.slave (rdy, clear, producer ports, full flags,
//              cdb_valid/rob_id/value/src, overflow_err)
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int ROB_ID_W   = ROBSIZE,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  io_bus
);

  localparam int EW = ROB_ID_W + 32;

  logic [EW-1:0]       w_alu_head;
  logic [EW-1:0]       w_lsb_head;
  logic                w_alu_empty;
  logic                w_lsb_empty;
  logic                w_alu_full;
  logic                w_lsb_full;
  logic                w_alu_pop;
  logic                w_lsb_pop;
  logic                w_grant;
  cdb_src_e            w_grant_src;
  logic [EW-1:0]       w_grant_head;

  logic                r_cdb_valid;
  logic [ROB_ID_W-1:0] r_cdb_rob_id;
  logic [31:0]         r_cdb_value;
  cdb_src_e            r_cdb_src;
  cdb_src_e            r_last_grant;
  logic                r_overflow;

  cdb_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_alu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_rdy   (io_bus.rdy),
    .i_clear (io_bus.clear),
    .i_push  (io_bus.alu_valid),
    .i_data  ({io_bus.alu_rob_id, io_bus.alu_value}),
    .i_pop   (w_alu_pop),
    .o_head  (w_alu_head),
    .o_empty (w_alu_empty),
    .o_full  (w_alu_full)
  );

  cdb_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_lsb_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_rdy   (io_bus.rdy),
    .i_clear (io_bus.clear),
    .i_push  (io_bus.lsb_valid),
    .i_data  ({io_bus.lsb_rob_id, io_bus.lsb_value}),
    .i_pop   (w_lsb_pop),
    .o_head  (w_lsb_head),
    .o_empty (w_lsb_empty),
    .o_full  (w_lsb_full)
  );

  always_comb begin
    w_grant      = !w_alu_empty || !w_lsb_empty;
    w_grant_src  = rr_pick(!w_alu_empty, !w_lsb_empty, r_last_grant);
    w_grant_head = (w_grant_src == CDB_SRC_ALU) ? w_alu_head : w_lsb_head;
  end

  // The FIFOs already ignore pops while rdy is low or clear is high.
  assign w_alu_pop = w_grant && (w_grant_src == CDB_SRC_ALU);
  assign w_lsb_pop = w_grant && (w_grant_src == CDB_SRC_LSB);

  // Reset leaves last_grant on LSB so the ALU wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_value  <= '0;
      r_cdb_src    <= CDB_SRC_ALU;
      r_last_grant <= CDB_SRC_LSB;
      r_overflow   <= 1'b0;
    end else if (io_bus.rdy) begin
      if (io_bus.clear) begin
        r_cdb_valid <= 1'b0;
      end else begin
        r_cdb_valid <= w_grant;
        if (w_grant) begin
          r_cdb_rob_id <= w_grant_head[EW-1:32];
          r_cdb_value  <= w_grant_head[31:0];
          r_cdb_src    <= w_grant_src;
          r_last_grant <= w_grant_src;
        end
        if ((io_bus.alu_valid && w_alu_full) || (io_bus.lsb_valid && w_lsb_full))
          r_overflow <= 1'b1;
      end
    end
  end

  assign io_bus.alu_full     = w_alu_full;
  assign io_bus.lsb_full     = w_lsb_full;
  assign io_bus.cdb_valid    = r_cdb_valid;
  assign io_bus.cdb_rob_id   = r_cdb_rob_id;
  assign io_bus.cdb_value    = r_cdb_value;
  assign io_bus.cdb_src      = r_cdb_src;
  assign io_bus.overflow_err = r_overflow;

endmodule
